// File: rtl/usb_rx_pkg.sv
// rtl/usb_rx_pkg.sv - shared USB receive-path constants
package usb_rx_pkg;

    localparam int USB_STUFF_LIMIT = 6;
    localparam int USB_BYTE_BITS   = 8;

    // Counter width able to hold 0..max_val; never narrower than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

    localparam int USB_BIT_CNT_W  = cnt_width(USB_BYTE_BITS - 1);
    localparam int USB_ONES_CNT_W = cnt_width(USB_STUFF_LIMIT);

endpackage

// File: rtl/rx_shift_reg.sv
// rtl/rx_shift_reg.sv - serial-in parallel-out shift register, LSB-first fill
module rx_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift_en,
    input  logic             din,
    output logic [WIDTH-1:0] q
);

    // New bits enter at the MSB so the first bit received ends up at bit 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (shift_en) begin
            q <= {din, q[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/usb_rx_unstuff_shift.sv
// rtl/usb_rx_unstuff_shift.sv - USB bit unstuffing and LSB-first byte assembly
module usb_rx_unstuff_shift
    import usb_rx_pkg::*;
#(
    parameter int BYTE_BITS   = USB_BYTE_BITS,
    parameter int STUFF_LIMIT = USB_STUFF_LIMIT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 d_orig,
    input  logic                 shift_enable,
    input  logic                 eop,
    input  logic                 rcving,
    output logic [BYTE_BITS-1:0] rx_data,
    output logic                 byte_ready,
    output logic                 stuff_err,
    output logic                 align_err
);

    localparam int BIT_CNT_W  = cnt_width(BYTE_BITS - 1);
    localparam int ONES_CNT_W = cnt_width(STUFF_LIMIT);

    localparam logic [BIT_CNT_W-1:0]  LAST_BIT   = BIT_CNT_W'(BYTE_BITS - 1);
    localparam logic [ONES_CNT_W-1:0] STUFF_SLOT = ONES_CNT_W'(STUFF_LIMIT);

    logic [BYTE_BITS-1:0]  sr;
    logic [BYTE_BITS-1:0]  sr_next;
    logic [BIT_CNT_W-1:0]  bit_cnt;
    logic [ONES_CNT_W-1:0] ones_cnt;
    logic                  event_ok;
    logic                  stuff_slot;
    logic                  data_bit;

    assign event_ok   = shift_enable && rcving;
    assign stuff_slot = (ones_cnt == STUFF_SLOT);
    assign data_bit   = event_ok && !eop && !stuff_slot;
    assign sr_next    = {d_orig, sr[BYTE_BITS-1:1]};

    rx_shift_reg #(
        .WIDTH(BYTE_BITS)
    ) u_shift (
        .clk     (clk),
        .rst     (rst),
        .shift_en(data_bit),
        .din     (d_orig),
        .q       (sr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data    <= '0;
            bit_cnt    <= '0;
            ones_cnt   <= '0;
            byte_ready <= 1'b0;
            stuff_err  <= 1'b0;
            align_err  <= 1'b0;
        end else begin
            byte_ready <= 1'b0;
            stuff_err  <= 1'b0;
            align_err  <= 1'b0;
            if (!rcving) begin
                bit_cnt  <= '0;
                ones_cnt <= '0;
            end else if (shift_enable) begin
                if (eop) begin
                    // A partial byte at end of packet is dropped, not delivered.
                    align_err <= (bit_cnt != '0);
                    bit_cnt   <= '0;
                    ones_cnt  <= '0;
                end else if (stuff_slot) begin
                    stuff_err <= d_orig;
                    ones_cnt  <= '0;
                end else begin
                    // Run length carries across byte boundaries on purpose.
                    ones_cnt <= d_orig ? ones_cnt + 1'b1 : '0;
                    if (bit_cnt == LAST_BIT) begin
                        rx_data    <= sr_next;
                        byte_ready <= 1'b1;
                        bit_cnt    <= '0;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_usb_rx_unstuff_shift.sv
// tb/tb_usb_rx_unstuff_shift.sv - randomized and directed bench for usb_rx_unstuff_shift
module tb_usb_rx_unstuff_shift;

    logic       clk;
    logic       rst;
    logic       d_orig;
    logic       shift_enable;
    logic       eop;
    logic       rcving;
    logic [7:0] rx_data;
    logic       byte_ready;
    logic       stuff_err;
    logic       align_err;

    int n_checks;
    int n_pass;
    int cnt_ready;
    int cnt_stuff;
    int cnt_align;

    // Reference: bits of the byte in progress, current run of ones, last byte.
    int m_bits[$];
    int m_ones;
    int m_rx;

    usb_rx_unstuff_shift dut (
        .clk         (clk),
        .rst         (rst),
        .d_orig      (d_orig),
        .shift_enable(shift_enable),
        .eop         (eop),
        .rcving      (rcving),
        .rx_data     (rx_data),
        .byte_ready  (byte_ready),
        .stuff_err   (stuff_err),
        .align_err   (align_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic step(input logic se, input logic d, input logic e, input logic rc, input logic r);
        int exp_ready;
        int exp_stuff;
        int exp_align;
        int v;
        shift_enable = se;
        d_orig       = d;
        eop          = e;
        rcving       = rc;
        rst          = r;
        @(posedge clk);
        #1;
        exp_ready = 0;
        exp_stuff = 0;
        exp_align = 0;
        if (r) begin
            m_bits.delete();
            m_ones = 0;
            m_rx   = 0;
        end else if (!rc) begin
            m_bits.delete();
            m_ones = 0;
        end else if (se) begin
            if (e) begin
                exp_align = (m_bits.size() != 0) ? 1 : 0;
                m_bits.delete();
                m_ones = 0;
            end else if (m_ones == 6) begin
                exp_stuff = d ? 1 : 0;
                m_ones = 0;
            end else begin
                m_bits.push_back(d ? 1 : 0);
                m_ones = d ? m_ones + 1 : 0;
                if (m_bits.size() == 8) begin
                    v = 0;
                    foreach (m_bits[i]) v += m_bits[i] * (1 << i);
                    m_rx = v;
                    exp_ready = 1;
                    m_bits.delete();
                end
            end
        end
        check("byte_ready", 32'(byte_ready), 32'(exp_ready));
        check("stuff_err", 32'(stuff_err), 32'(exp_stuff));
        check("align_err", 32'(align_err), 32'(exp_align));
        check("rx_data", 32'(rx_data), 32'(m_rx));
        cnt_ready += int'(byte_ready);
        cnt_stuff += int'(stuff_err);
        cnt_align += int'(align_err);
    endtask

    // One event followed by one idle cycle keeps the strobe spacing legal.
    task automatic send_raw(input logic d);
        step(1'b1, d, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic send_eop();
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    // Transmits a byte LSB-first, inserting a stuffed 0 wherever the line needs one.
    task automatic send_byte(input logic [7:0] b);
        logic [7:0] bb;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (m_ones == 6) send_raw(1'b0);
            send_raw(bb[i]);
        end
    endtask

    initial begin
        int r_ready;
        int r_stuff;
        int r_align;
        logic [7:0] bits5;
        n_checks = 0;
        n_pass   = 0;
        cnt_ready = 0;
        cnt_stuff = 0;
        cnt_align = 0;
        m_ones = 0;
        m_rx   = 0;
        shift_enable = 1'b0;
        d_orig = 1'b0;
        eop    = 1'b0;
        rcving = 1'b1;
        rst    = 1'b1;

        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        check("reset_rx_data", 32'(rx_data), 32'h0);

        send_byte(8'hA5);
        check("byte_a5", 32'(rx_data), 32'hA5);
        check("a5_ready_cnt", 32'(cnt_ready), 32'd1);

        send_byte(8'hFF);
        check("byte_ff", 32'(rx_data), 32'hFF);

        send_byte(8'h80);
        check("byte_80", 32'(rx_data), 32'h80);
        send_byte(8'h1F);
        check("byte_1f", 32'(rx_data), 32'h1F);
        check("no_stuff_err_yet", 32'(cnt_stuff), 32'd0);

        for (int i = 0; i < 6; i++) send_raw(1'b1);
        send_raw(1'b1);
        check("stuff_err_cnt", 32'(cnt_stuff), 32'd1);
        send_raw(1'b0);
        send_raw(1'b1);
        check("byte_after_stuff_err", 32'(rx_data), 32'hBF);

        send_raw(1'b1);
        send_raw(1'b0);
        send_raw(1'b1);
        send_eop();
        check("align_err_cnt", 32'(cnt_align), 32'd1);
        check("rx_held_after_eop", 32'(rx_data), 32'hBF);
        send_byte(8'h3C);
        check("byte_3c", 32'(rx_data), 32'h3C);

        bits5 = 8'h1B;
        for (int i = 0; i < 5; i++) send_raw(bits5[i]);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        r_ready = cnt_ready;
        send_byte(8'h96);
        check("byte_96_after_rst", 32'(rx_data), 32'h96);
        check("single_ready_96", 32'(cnt_ready - r_ready), 32'd1);

        for (int i = 0; i < 5; i++) send_raw(bits5[i]);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("rx_held_rcving_low", 32'(rx_data), 32'h96);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        send_byte(8'h69);
        check("byte_69_after_rcving", 32'(rx_data), 32'h69);

        r_stuff = cnt_stuff;
        r_align = cnt_align;
        for (int n = 0; n < 1500; n++) begin
            logic rd;
            logic re;
            logic rrc;
            logic rr;
            rd  = ($urandom_range(0, 99) < 80);
            re  = ($urandom_range(0, 29) == 0);
            rrc = ($urandom_range(0, 49) != 0);
            rr  = ($urandom_range(0, 199) == 0);
            step(1'b1, rd, re, rrc, rr);
            check("pulse_onehot", 32'(int'(byte_ready) + int'(stuff_err) + int'(align_err) <= 1), 32'd1);
            for (int g = 0; g < int'($urandom_range(1, 3)); g++)
                step(1'b0, logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)), 1'b1, 1'b0);
        end
        check("random_saw_stuff_err", 32'(cnt_stuff > r_stuff), 32'd1);
        check("random_saw_align_err", 32'(cnt_align > r_align), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/usb_rx_unstuff_shift.md
# usb_rx_unstuff_shift

Receive-path stage directly downstream of the NRZI decoder. Consumes the decoded bit stream (`d_orig`) on each `shift_enable` strobe, removes USB stuffed bits (the bit following six consecutive ones), and assembles bytes LSB-first. Each completed byte is presented to the RX control FSM with a one-cycle `byte_ready` pulse. Stuffing violations and partial bytes at EOP are flagged.

## Interface
- `BYTE_BITS`, default 8: data bits per assembled byte.
- `STUFF_LIMIT`, default 6: consecutive ones after which the next bit is a stuffed bit.
- `clk` in 1: system clock, all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `d_orig` in 1: decoded data bit from the NRZI decoder.
- `shift_enable` in 1: one-cycle strobe; `d_orig` is sampled only in cycles where this is high.
- `eop` in 1: end-of-packet indication, qualified by `shift_enable`.
- `rcving` in 1: packet-active level from RX control; low clears the counters.
- `rx_data` out BYTE_BITS: last completed byte, LSB = first bit received.
- `byte_ready` out 1: one-cycle pulse, `rx_data` newly valid.
- `stuff_err` out 1: one-cycle pulse, stuffed-bit position carried a 1.
- `align_err` out 1: one-cycle pulse, EOP arrived with a partial byte.

## Operation
- Internal state:
  - shift register `sr` [BYTE_BITS].
  - `bit_cnt` 0..BYTE_BITS-1.
  - `ones_cnt` 0..STUFF_LIMIT.
- An event is a cycle with `shift_enable=1`, `rcving=1` and `rst=0`. Priority is `rst` > `rcving=0` > `eop` > data/stuff.
- **Reset:** `rx_data=0`, `sr=0`, both counters 0, `byte_ready=stuff_err=align_err=0`.
- **`rcving=0` (any cycle):**
  - `bit_cnt` and `ones_cnt` clear to 0.
  - No shift occurs.
  - `rx_data` holds its value.
  - All pulse outputs are 0 the next cycle.
- **Event with `eop=1`:**
  - No shift; both counters clear.
  - If `bit_cnt != 0`, `align_err` pulses and the partial byte is discarded (`rx_data` unchanged).
- **Event, `eop=0`, `ones_cnt == STUFF_LIMIT` (stuffed-bit slot):**
  - The bit is dropped, not shifted; `bit_cnt` is unchanged; `ones_cnt` becomes 0.
  - If `d_orig=1`, `stuff_err` pulses. Reception continues; no other state is altered.
- **Event, `eop=0`, otherwise (data bit):**
  - `sr <= {d_orig, sr[BYTE_BITS-1:1]}`.
  - `ones_cnt <= d_orig ? ones_cnt+1 : 0`.
  - If `bit_cnt == BYTE_BITS-1`: `rx_data <= {d_orig, sr[BYTE_BITS-1:1]}`, `byte_ready` pulses, `bit_cnt` wraps to 0.
  - Else `bit_cnt` increments.
- `ones_cnt` is not cleared at byte boundaries; a run of ones spanning two bytes still triggers a stuffed-bit slot.
- Width rules:
  - `bit_cnt` is $clog2(BYTE_BITS) bits, wrapping exactly at BYTE_BITS-1.
  - `ones_cnt` is $clog2(STUFF_LIMIT+1) bits and never exceeds STUFF_LIMIT.

## Timing
- All outputs are registered.
- Latency: `byte_ready` and the new `rx_data` appear in the cycle after the event carrying the final data bit.
- `rx_data` is stable from that cycle until the next `byte_ready`.
- Pulse outputs are exactly one cycle wide; at most one of them is high in any cycle.
- There is no back-pressure. `shift_enable` is spaced ≥ 2 cycles apart (nominally 8 at 12 Mb/s over a 96 MHz clock), so consumers have ≥ 2 cycles to capture `rx_data`.
- Reset asserted mid-byte clears all state at the next edge. The first event after `rst` deasserts is treated as bit 0.

## Structure
- Shared package `usb_rx_pkg` holds:
  - `localparam USB_STUFF_LIMIT = 6`.
  - `localparam USB_BYTE_BITS = 8`.
  - The counter-width helper constants.
  - These are shared with the NRZI decoder and RX control.
- One natural sub-module, `rx_shift_reg`: a BYTE_BITS-wide serial-in/parallel-out shift register with a shift-enable and a parallel output. The unstuff counters and output registers stay in the top.

## Test plan
- Byte 0xA5 (bits 1,0,1,0,0,1,0,1) on 8 events -> one `byte_ready` pulse, `rx_data=0xA5`, no errors.
- Byte 0xFF (six 1s, stuffed 0, two 1s) -> `rx_data=0xFF`, stuffed bit dropped, `byte_ready` after the 9th event, `stuff_err=0`.
- 0x80 followed by 0x1F (ones run spanning the boundary, stuffed 0 after bit 4 of the second byte) -> `rx_data=0x80` then `0x1F`, no error.
- Six 1s then 1 in the stuff slot -> `stuff_err` pulse one cycle; the next 2 data bits complete the byte with the offending bit absent.
- Three data bits then an `eop` event -> `align_err` pulse, `rx_data` unchanged. A following full byte 0x3C is received correctly.
- `rst` (or `rcving=0`) after 5 bits -> counters clear. The next 8 bits form 0x96 with a single `byte_ready`.
